// File: rtl/frame_sync_buffer.sv
// rtl/frame_sync_buffer.sv - game-state snapshot transfer from the 60 Hz tick domain into the VGA pixel domain
// Optional build macro: FRAME_SYNC_STATS_EN (adds drop_count and tear_guard_err)
module frame_sync_buffer #(
    parameter int N_OBS         = 10,
    parameter int X_W           = 10,
    parameter int Y_W           = 9,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n_debounced,
    input  logic                 game_tick,
    input  logic                 vblank,
    input  logic [N_OBS*X_W-1:0] obs_x_left_in,
    input  logic [N_OBS*X_W-1:0] obs_x_right_in,
    input  logic [N_OBS*Y_W-1:0] obs_y_up_in,
    input  logic [N_OBS*Y_W-1:0] obs_y_down_in,
    input  logic [Y_W-1:0]       player_y_in,
    input  logic [1:0]           gamemode_in,
    output logic [N_OBS*X_W-1:0] obs_x_left,
    output logic [N_OBS*X_W-1:0] obs_x_right,
    output logic [N_OBS*Y_W-1:0] obs_y_up,
    output logic [N_OBS*Y_W-1:0] obs_y_down,
    output logic [Y_W-1:0]       player_y,
    output logic [1:0]           gamemode,
`ifdef FRAME_SYNC_STATS_EN
    output logic [15:0]          drop_count,
    output logic                 tear_guard_err,
`endif
    output logic                 frame_swap,
    output logic                 pending_valid
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // Reset images: obstacles parked off-screen, player mid-screen
    localparam logic [N_OBS*X_W-1:0] X_RST  = {N_OBS{X_W'(700)}};
    localparam logic [N_OBS*Y_W-1:0] Y_RST  = {N_OBS{Y_W'(500)}};
    localparam logic [Y_W-1:0]       PY_RST = Y_W'(240);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             capture;

    logic s1, s2, s3;
    logic vblank_d;
    logic tick_rise;
    logic vblank_rise;
    logic swap;

    logic [N_OBS*X_W-1:0] pend_x_left, pend_x_right;
    logic [N_OBS*Y_W-1:0] pend_y_up, pend_y_down;
    logic [Y_W-1:0]       pend_player_y;
    logic [1:0]           pend_gamemode;

    assign tick_rise   = s2 & ~s3;
    assign vblank_rise = vblank & ~vblank_d;
    assign swap        = vblank_rise & pending_valid;

    // Tick synchronizer plus edge-detect stage, and vblank edge delay
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            vblank_d <= 1'b0;
        end else begin
            s1       <= game_tick;
            s2       <= s1;
            s3       <= s2;
            vblank_d <= vblank;
        end
    end

    // Capture FSM state and settle counter registers
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: wait out the settle window after a tick edge, then capture once
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (tick_rise) begin
                    cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pending buffer: newest snapshot wins; a capture beats a same-cycle swap for the valid flag
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            pend_x_left   <= X_RST;
            pend_x_right  <= X_RST;
            pend_y_up     <= Y_RST;
            pend_y_down   <= Y_RST;
            pend_player_y <= PY_RST;
            pend_gamemode <= 2'd0;
            pending_valid <= 1'b0;
        end else begin
            if (capture) begin
                pend_x_left   <= obs_x_left_in;
                pend_x_right  <= obs_x_right_in;
                pend_y_up     <= obs_y_up_in;
                pend_y_down   <= obs_y_down_in;
                pend_player_y <= player_y_in;
                pend_gamemode <= gamemode_in;
                pending_valid <= 1'b1;
            end else if (swap) begin
                pending_valid <= 1'b0;
            end
        end
    end

    // Display buffer: updated only at the first cycle of vertical blanking
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            obs_x_left  <= X_RST;
            obs_x_right <= X_RST;
            obs_y_up    <= Y_RST;
            obs_y_down  <= Y_RST;
            player_y    <= PY_RST;
            gamemode    <= 2'd0;
            frame_swap  <= 1'b0;
        end else begin
            frame_swap <= swap;
            if (swap) begin
                obs_x_left  <= pend_x_left;
                obs_x_right <= pend_x_right;
                obs_y_up    <= pend_y_up;
                obs_y_down  <= pend_y_down;
                player_y    <= pend_player_y;
                gamemode    <= pend_gamemode;
            end
        end
    end

`ifdef FRAME_SYNC_STATS_EN
    // Overwritten-snapshot counter (saturating) and sticky mid-frame swap flag
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            drop_count     <= 16'd0;
            tear_guard_err <= 1'b0;
        end else begin
            if (capture && pending_valid && !swap && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            if (swap && !vblank) begin
                tear_guard_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_sync_buffer.sv
// tb/tb_frame_sync_buffer.sv - randomized self-checking bench for frame_sync_buffer with a snapshot-level reference model
module tb_frame_sync_buffer;

    localparam int N_OBS  = 10;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int SETTLE = 4;
    localparam int XB     = N_OBS * X_W;
    localparam int YB     = N_OBS * Y_W;

    logic          clk = 1'b0;
    logic          rst_n_debounced = 1'b0;
    logic          game_tick = 1'b0;
    logic          vblank = 1'b0;
    logic [XB-1:0] obs_x_left_in = '0, obs_x_right_in = '0;
    logic [YB-1:0] obs_y_up_in = '0, obs_y_down_in = '0;
    logic [Y_W-1:0] player_y_in = '0;
    logic [1:0]    gamemode_in = '0;
    logic [XB-1:0] obs_x_left, obs_x_right;
    logic [YB-1:0] obs_y_up, obs_y_down;
    logic [Y_W-1:0] player_y;
    logic [1:0]    gamemode;
    logic          frame_swap, pending_valid;
`ifdef FRAME_SYNC_STATS_EN
    logic [15:0]   drop_count;
    logic          tear_guard_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    frame_sync_buffer #(.N_OBS(N_OBS), .X_W(X_W), .Y_W(Y_W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk),
        .rst_n_debounced(rst_n_debounced),
        .game_tick(game_tick),
        .vblank(vblank),
        .obs_x_left_in(obs_x_left_in),
        .obs_x_right_in(obs_x_right_in),
        .obs_y_up_in(obs_y_up_in),
        .obs_y_down_in(obs_y_down_in),
        .player_y_in(player_y_in),
        .gamemode_in(gamemode_in),
        .obs_x_left(obs_x_left),
        .obs_x_right(obs_x_right),
        .obs_y_up(obs_y_up),
        .obs_y_down(obs_y_down),
        .player_y(player_y),
        .gamemode(gamemode),
`ifdef FRAME_SYNC_STATS_EN
        .drop_count(drop_count),
        .tear_guard_err(tear_guard_err),
`endif
        .frame_swap(frame_swap),
        .pending_valid(pending_valid)
    );

    always #20 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: snapshots as whole records, captures scheduled a fixed latency after the tick is seen
    typedef struct packed {
        logic [XB-1:0]  xl;
        logic [XB-1:0]  xr;
        logic [YB-1:0]  yu;
        logic [YB-1:0]  yd;
        logic [Y_W-1:0] py;
        logic [1:0]     gm;
    } snap_t;

    function automatic snap_t reset_snap();
        snap_t s;
        for (int i = 0; i < N_OBS; i++) begin
            s.xl[i*X_W +: X_W] = X_W'(700);
            s.xr[i*X_W +: X_W] = X_W'(700);
            s.yu[i*Y_W +: Y_W] = Y_W'(500);
            s.yd[i*Y_W +: Y_W] = Y_W'(500);
        end
        s.py = Y_W'(240);
        s.gm = 2'd0;
        return s;
    endfunction

    snap_t m_disp, m_pend;
    bit    m_pv, m_swap, m_tick_prev, m_vb_prev;
    int    m_drop;
    int    m_cap_q[$];
    int    cyc = 0;

    initial begin
        snap_t in_s;
        bit sw, cap, accept;
        m_disp = reset_snap();
        m_pend = reset_snap();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n_debounced) begin
                m_disp = reset_snap();
                m_pend = reset_snap();
                m_pv = 0; m_swap = 0; m_tick_prev = 0; m_vb_prev = 0; m_drop = 0;
                m_cap_q.delete();
            end else begin
                in_s = '{obs_x_left_in, obs_x_right_in, obs_y_up_in, obs_y_down_in, player_y_in, gamemode_in};
                sw  = vblank && !m_vb_prev && m_pv;
                cap = (m_cap_q.size() > 0) && (m_cap_q[0] == cyc);
                accept = game_tick && !m_tick_prev &&
                         ((m_cap_q.size() == 0) || (cyc + 1 >= m_cap_q[$]));
                if (sw) m_disp = m_pend;
                if (cap) begin
                    if (m_pv && !sw && m_drop < 16'hFFFF) m_drop++;
                    m_pend = in_s;
                    m_pv = 1;
                    void'(m_cap_q.pop_front());
                end else if (sw) begin
                    m_pv = 0;
                end
                if (accept) m_cap_q.push_back(cyc + 3 + SETTLE);
                m_swap = sw;
                m_tick_prev = game_tick;
                m_vb_prev = vblank;
            end
            #1;
            check_val("frame_swap", 128'(frame_swap), 128'(m_swap));
            check_val("pending_valid", 128'(pending_valid), 128'(m_pv));
            check_val("player_y", 128'(player_y), 128'(m_disp.py));
            check_val("gamemode", 128'(gamemode), 128'(m_disp.gm));
            check_val("obs_x_left", 128'(obs_x_left), 128'(m_disp.xl));
            check_val("obs_x_right", 128'(obs_x_right), 128'(m_disp.xr));
            check_val("obs_y_up", 128'(obs_y_up), 128'(m_disp.yu));
            check_val("obs_y_down", 128'(obs_y_down), 128'(m_disp.yd));
`ifdef FRAME_SYNC_STATS_EN
            check_val("drop_count", 128'(drop_count), 128'(m_drop));
            check_val("tear_guard_err", 128'(tear_guard_err), 128'(0));
`endif
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_data(input logic [Y_W-1:0] py, input logic [1:0] gm);
        for (int i = 0; i < N_OBS; i++) begin
            obs_x_left_in[i*X_W +: X_W]  = X_W'($urandom);
            obs_x_right_in[i*X_W +: X_W] = X_W'($urandom);
            obs_y_up_in[i*Y_W +: Y_W]    = Y_W'($urandom);
            obs_y_down_in[i*Y_W +: Y_W]  = Y_W'($urandom);
        end
        player_y_in = py;
        gamemode_in = gm;
    endtask

    // Tick high for 4 cycles with fresh data, then idle for the rest of the gap
    task automatic send_tick(input logic [Y_W-1:0] py, input logic [1:0] gm, input int gap);
        rand_data(py, gm);
        game_tick = 1'b1;
        wait_neg(4);
        game_tick = 1'b0;
        wait_neg(gap - 4);
    endtask

    task automatic vblank_pulse(input int hi, input int lo);
        vblank = 1'b1;
        wait_neg(hi);
        vblank = 1'b0;
        wait_neg(lo);
    endtask

    task automatic check_reset_outputs(input string tag);
        snap_t r;
        r = reset_snap();
        check_val({tag, "_player_y"}, 128'(player_y), 128'(r.py));
        check_val({tag, "_gamemode"}, 128'(gamemode), 128'(r.gm));
        check_val({tag, "_obs_x_left"}, 128'(obs_x_left), 128'(r.xl));
        check_val({tag, "_obs_y_up"}, 128'(obs_y_up), 128'(r.yu));
        check_val({tag, "_frame_swap"}, 128'(frame_swap), 128'(0));
        check_val({tag, "_pending_valid"}, 128'(pending_valid), 128'(0));
    endtask

    initial begin
        int tick_t, tick_hi, vb_t;
        wait_neg(3);
        check_reset_outputs("reset");
        rst_n_debounced = 1'b1;
        wait_neg(5);

        // No ticks, three vblank pulses: nothing should move
        repeat (3) vblank_pulse(10, 20);

        // Single tick, then swap at the next vblank rise
        send_tick(Y_W'(100), 2'd1, 20);
        vblank_pulse(10, 20);

        // Two ticks within one frame: newest snapshot wins
        send_tick(Y_W'(50), 2'd2, 20);
        send_tick(Y_W'(60), 2'd3, 20);
        vblank_pulse(10, 20);

        // Capture edge coincides with vblank rise
        send_tick(Y_W'(30), 2'd1, 20);
        rand_data(Y_W'(40), 2'd2);
        game_tick = 1'b1;
        wait_neg(4);
        game_tick = 1'b0;
        wait_neg(3);
        vblank = 1'b1;
        wait_neg(10);
        vblank = 1'b0;
        wait_neg(20);
        vblank_pulse(10, 20);

        // Long vblank with a capture inside: no swap until the next rise
        vblank = 1'b1;
        wait_neg(30);
        send_tick(Y_W'(77), 2'd3, 40);
        wait_neg(130);
        vblank = 1'b0;
        wait_neg(40);
        vblank_pulse(10, 20);

        // Prime a visible snapshot so the reset is observable, then reset mid-settle
        send_tick(Y_W'(11), 2'd2, 20);
        vblank_pulse(10, 20);
        rand_data(Y_W'(200), 2'd3);
        obs_x_left_in[X_W-1:0] = X_W'(123);
        game_tick = 1'b1;
        wait_neg(4);
        game_tick = 1'b0;
        #3;
        rst_n_debounced = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        wait_neg(3);
        rst_n_debounced = 1'b1;
        wait_neg(20);
        vblank_pulse(10, 20);
        check_reset_outputs("post_reset");

        // Randomized traffic: independent tick and vblank timelines
        tick_t = 5; tick_hi = 0; vb_t = 30;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (tick_hi > 0) begin
                tick_hi--;
                if (tick_hi == 0) game_tick = 1'b0;
            end
            if (tick_t == 0) begin
                rand_data(Y_W'($urandom), 2'($urandom));
                game_tick = 1'b1;
                tick_hi = $urandom_range(2, 5);
                tick_t = $urandom_range(12, 45);
            end else begin
                tick_t--;
            end
            if (vb_t == 0) begin
                vblank = ~vblank;
                vb_t = vblank ? $urandom_range(3, 60) : $urandom_range(20, 80);
            end else begin
                vb_t--;
            end
        end

        wait_neg(5);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
